// File: rtl/bram_loader_pkg.sv
// -----------------------------------------------------------------------------
// bram_loader_pkg
//   Shared types and constants for the BRAM byte loader.
//   - state_t : loader FSM states (IDLE, RECV, WRITE, DONE)
//   - LANES   : byte lanes per BRAM word
//   - BYTE_W  : width of one stream byte
//   - WORD_W  : BRAM word width (LANES * BYTE_W)
//   - lane_bit(): one-hot write-enable bit for a lane index
// -----------------------------------------------------------------------------
package bram_loader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int LANES  = 4;
    localparam int BYTE_W = 8;
    localparam int WORD_W = LANES * BYTE_W;

    // One-hot mask bit for the given lane.
    function automatic logic [LANES-1:0] lane_bit(input logic [1:0] lane);
        logic [LANES-1:0] m;
        m = 4'b0001 << lane;
        return m;
    endfunction

endpackage

// File: rtl/bram_byte_loader.sv
// -----------------------------------------------------------------------------
// bram_byte_loader
//   Packs an 8-bit valid/ready/last byte stream little-endian into 32-bit
//   words and writes them through one BRAM port, starting at base_addr and
//   incrementing the word address (modulo 2^addr_width) per word.
//
// Ports
//   clk, reset            : rising-edge clock, asynchronous active-high reset
//   start, base_addr      : begin a load at base_addr (accepted in IDLE only)
//   byte_data/valid/last  : input byte stream; byte_ready accepts a byte
//   busy                  : load in progress (RECV/WRITE/DONE)
//   done                  : one-cycle pulse after the final write
//   wrapped               : sticky, word address rolled over to 0 this load
//   words_written         : BRAM writes issued in the current/last load
//   bram_clken/addr/we/data : BRAM write port; we lane i covers bits [8i+7:8i]
// -----------------------------------------------------------------------------
module bram_byte_loader
    import bram_loader_pkg::*;
#(
    parameter int addr_width = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [addr_width-1:0] base_addr,
    input  logic [BYTE_W-1:0]     byte_data,
    input  logic                  byte_valid,
    input  logic                  byte_last,
    output logic                  byte_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  wrapped,
    output logic [addr_width:0]   words_written,
    output logic                  bram_clken,
    output logic [addr_width-1:0] bram_addr,
    output logic [LANES-1:0]      bram_we,
    output logic [WORD_W-1:0]     bram_data
);

    localparam logic [addr_width-1:0] ADDR_MAX = {addr_width{1'b1}};
    localparam logic [addr_width-1:0] ADDR_ONE = {{(addr_width-1){1'b0}}, 1'b1};
    localparam logic [addr_width:0]   CNT_ONE  = {{addr_width{1'b0}}, 1'b1};

    state_t                state_r, state_next_s;
    logic [addr_width-1:0] addr_r, addr_next_s;
    logic [1:0]            lane_r, lane_next_s;
    logic [LANES-1:0]      mask_r, mask_next_s;
    logic [WORD_W-1:0]     word_r, word_next_s;
    logic                  last_r, last_next_s;
    logic [addr_width:0]   ww_r, ww_next_s;
    logic                  wrapped_r, wrapped_next_s;
    logic                  accept_s;

    logic                  byte_ready_r, busy_r, done_r, bram_clken_r;
    logic [addr_width-1:0] bram_addr_r;
    logic [LANES-1:0]      bram_we_r;
    logic [WORD_W-1:0]     bram_data_r;

    logic                  byte_ready_s, busy_s, done_s, bram_clken_s;
    logic [addr_width-1:0] bram_addr_s;
    logic [LANES-1:0]      bram_we_s;
    logic [WORD_W-1:0]     bram_data_s;

    // byte_ready_r is high exactly while the FSM sits in RECV.
    assign accept_s = byte_valid & byte_ready_r;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_next_s = RECV;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RECV: begin
                if (accept_s && ((lane_r == 2'd3) || byte_last)) begin
                    state_next_s = WRITE;
                end else begin
                    state_next_s = RECV;
                end
            end
            WRITE: begin
                if (last_r) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = RECV;
                end
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Datapath next values: lane packing, address walk, counters.
    always_comb begin
        addr_next_s    = addr_r;
        lane_next_s    = lane_r;
        mask_next_s    = mask_r;
        word_next_s    = word_r;
        last_next_s    = last_r;
        ww_next_s      = ww_r;
        wrapped_next_s = wrapped_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    addr_next_s    = base_addr;
                    lane_next_s    = 2'd0;
                    mask_next_s    = {LANES{1'b0}};
                    word_next_s    = {WORD_W{1'b0}};
                    last_next_s    = 1'b0;
                    ww_next_s      = {(addr_width+1){1'b0}};
                    wrapped_next_s = 1'b0;
                end else begin
                    addr_next_s    = addr_r;
                end
            end
            RECV: begin
                if (accept_s) begin
                    case (lane_r)
                        2'd0:    word_next_s[7:0]   = byte_data;
                        2'd1:    word_next_s[15:8]  = byte_data;
                        2'd2:    word_next_s[23:16] = byte_data;
                        2'd3:    word_next_s[31:24] = byte_data;
                        default: word_next_s        = word_r;
                    endcase
                    mask_next_s = mask_r | lane_bit(lane_r);
                    lane_next_s = lane_r + 2'd1;
                    last_next_s = byte_last;
                end else begin
                    word_next_s = word_r;
                end
            end
            WRITE: begin
                ww_next_s   = ww_r + CNT_ONE;
                lane_next_s = 2'd0;
                mask_next_s = {LANES{1'b0}};
                word_next_s = {WORD_W{1'b0}};
                if (!last_r) begin
                    addr_next_s = addr_r + ADDR_ONE;
                    if (addr_r == ADDR_MAX) begin
                        wrapped_next_s = 1'b1;
                    end else begin
                        wrapped_next_s = wrapped_r;
                    end
                end else begin
                    addr_next_s = addr_r;
                end
            end
            DONE: begin
                last_next_s = 1'b0;
            end
            default: begin
                lane_next_s = 2'd0;
                mask_next_s = {LANES{1'b0}};
                word_next_s = {WORD_W{1'b0}};
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_r    <= {addr_width{1'b0}};
            lane_r    <= 2'd0;
            mask_r    <= {LANES{1'b0}};
            word_r    <= {WORD_W{1'b0}};
            last_r    <= 1'b0;
            ww_r      <= {(addr_width+1){1'b0}};
            wrapped_r <= 1'b0;
        end else begin
            addr_r    <= addr_next_s;
            lane_r    <= lane_next_s;
            mask_r    <= mask_next_s;
            word_r    <= word_next_s;
            last_r    <= last_next_s;
            ww_r      <= ww_next_s;
            wrapped_r <= wrapped_next_s;
        end
    end

    // Output decode from the upcoming state, so registered outputs line up
    // with the state they describe. Address/data only move on a write.
    always_comb begin
        byte_ready_s = (state_next_s == RECV);
        busy_s       = (state_next_s != IDLE);
        done_s       = (state_next_s == DONE);
        bram_clken_s = (state_next_s == WRITE);
        bram_addr_s  = bram_addr_r;
        bram_data_s  = bram_data_r;
        bram_we_s    = {LANES{1'b0}};
        if (state_next_s == WRITE) begin
            bram_we_s   = mask_next_s;
            bram_addr_s = addr_next_s;
            bram_data_s = word_next_s;
        end else begin
            bram_we_s   = {LANES{1'b0}};
        end
    end

    // Output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_ready_r <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            bram_clken_r <= 1'b0;
            bram_addr_r  <= {addr_width{1'b0}};
            bram_we_r    <= {LANES{1'b0}};
            bram_data_r  <= {WORD_W{1'b0}};
        end else begin
            byte_ready_r <= byte_ready_s;
            busy_r       <= busy_s;
            done_r       <= done_s;
            bram_clken_r <= bram_clken_s;
            bram_addr_r  <= bram_addr_s;
            bram_we_r    <= bram_we_s;
            bram_data_r  <= bram_data_s;
        end
    end

    assign byte_ready    = byte_ready_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign wrapped       = wrapped_r;
    assign words_written = ww_r;
    assign bram_clken    = bram_clken_r;
    assign bram_addr     = bram_addr_r;
    assign bram_we       = bram_we_r;
    assign bram_data     = bram_data_r;

endmodule

// File: tb/tb_bram_byte_loader.sv
// -----------------------------------------------------------------------------
// tb_bram_byte_loader
//   Self-checking bench for bram_byte_loader (addr_width = 12). A BRAM-port
//   monitor records every write; a reference model derives the expected
//   writes of a load directly from the byte list and base address.
// -----------------------------------------------------------------------------
module tb_bram_byte_loader;

    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [7:0]    byte_data;
    logic          byte_valid;
    logic          byte_last;
    logic          byte_ready;
    logic          busy;
    logic          done;
    logic          wrapped;
    logic [AW:0]   words_written;
    logic          bram_clken;
    logic [AW-1:0] bram_addr;
    logic [3:0]    bram_we;
    logic [31:0]   bram_data;

    bram_byte_loader #(.addr_width(AW)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .base_addr     (base_addr),
        .byte_data     (byte_data),
        .byte_valid    (byte_valid),
        .byte_last     (byte_last),
        .byte_ready    (byte_ready),
        .busy          (busy),
        .done          (done),
        .wrapped       (wrapped),
        .words_written (words_written),
        .bram_clken    (bram_clken),
        .bram_addr     (bram_addr),
        .bram_we       (bram_we),
        .bram_data     (bram_data)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // BRAM port monitor: {addr, we, data} of every write.
    logic [47:0] obs_q[$];
    int          done_cnt  = 0;
    int          stray_cnt = 0;

    always @(negedge clk) begin
        if (bram_clken) begin
            obs_q.push_back({bram_addr, bram_we, bram_data});
        end else if (bram_we != 4'd0) begin
            stray_cnt++;
        end
        if (done) done_cnt++;
    end

    // Bytes of the load currently being driven.
    logic [7:0] stim_q[$];

    // Reference: bytes fill words in order, byte k to word k/4 lane k%4.
    task automatic model_check(input logic [AW-1:0] base);
        int          n, nw;
        logic [47:0] exp_w;
        logic [AW-1:0] a;
        logic [3:0]  we;
        logic [31:0] d;
        n  = stim_q.size();
        nw = (n + 3) / 4;
        check("write_count", 64'(obs_q.size()), 64'(nw));
        for (int w = 0; w < nw; w++) begin
            a  = AW'(int'(base) + w);
            we = 4'd0;
            d  = 32'd0;
            for (int l = 0; l < 4; l++) begin
                if (w * 4 + l < n) begin
                    we[l]        = 1'b1;
                    d[8*l +: 8]  = stim_q[w * 4 + l];
                end
            end
            exp_w = {a, we, d};
            if (w < obs_q.size()) check($sformatf("write[%0d]", w), 64'(obs_q[w]), 64'(exp_w));
        end
        check("words_written", 64'(words_written), 64'(nw));
        check("wrapped", 64'(wrapped), 64'((int'(base) + nw - 1) > ((1 << AW) - 1)));
        check("done_count", 64'(done_cnt), 64'd1);
    endtask

    // Drive one full load from stim_q; optional random gaps and one stray
    // start pulse (with a different base) injected while busy.
    task automatic run_load(input logic [AW-1:0] base, input int gap_pct,
                            input int glitch_idx, input logic [AW-1:0] glitch_base);
        int n, idx, cyc;
        bit glitched;
        n = stim_q.size();
        @(posedge clk); #1;
        obs_q.delete();
        done_cnt = 0;
        @(negedge clk);
        start = 1'b1; base_addr = base;
        idx = 0; cyc = 0; glitched = 1'b0;
        while (idx < n && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            start     = 1'b0;
            base_addr = AW'($urandom);
            if (glitch_idx == idx && !glitched) begin
                start = 1'b1; base_addr = glitch_base;
                byte_valid = 1'b0; byte_data = 8'($urandom); byte_last = 1'($urandom);
                glitched = 1'b1;
            end else if (int'($urandom_range(99)) < gap_pct) begin
                byte_valid = 1'b0; byte_data = 8'($urandom); byte_last = 1'($urandom);
            end else begin
                byte_valid = 1'b1; byte_data = stim_q[idx]; byte_last = (idx == n - 1);
                if (byte_ready) idx++;
            end
        end
        if (cyc >= 1000) check("byte_accept_timeout", 64'(idx), 64'(n));
        @(negedge clk);
        byte_valid = 1'b0; byte_last = 1'b0; start = 1'b0;
        check("write_after_last_byte", 64'(bram_clken), 64'd1);
        cyc = 0;
        while (!done && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("done_seen", 64'(done), 64'd1);
        @(negedge clk);
        check("done_one_cycle", 64'(done), 64'd0);
        check("idle_after_done", 64'(busy), 64'd0);
        @(posedge clk); #1;
        model_check(base);
    endtask

    typedef struct {
        logic [AW-1:0] base;
        int            n;
        logic [7:0]    b [8];
        int            ww;
        logic          wr;
        logic [47:0]   first_w;
        logic [47:0]   last_w;
    } vec_t;

    vec_t vecs[5];

    task automatic set_vec(input int i, input logic [AW-1:0] base, input int n,
                           input logic [7:0] b0, input int ww, input logic wr,
                           input logic [47:0] fw, input logic [47:0] lw);
        vecs[i].base = base;
        vecs[i].n    = n;
        for (int k = 0; k < 8; k++) vecs[i].b[k] = 8'(int'(b0) + k);
        vecs[i].ww      = ww;
        vecs[i].wr      = wr;
        vecs[i].first_w = fw;
        vecs[i].last_w  = lw;
    endtask

    task automatic run_vec(input int i, input int gap_pct);
        stim_q.delete();
        for (int k = 0; k < vecs[i].n; k++) stim_q.push_back(vecs[i].b[k]);
        run_load(vecs[i].base, gap_pct, -1, '0);
        check($sformatf("vec%0d_ww", i), 64'(words_written), 64'(vecs[i].ww));
        check($sformatf("vec%0d_wrapped", i), 64'(wrapped), 64'(vecs[i].wr));
        check($sformatf("vec%0d_first", i), 64'(obs_q[0]), 64'(vecs[i].first_w));
        check($sformatf("vec%0d_last", i), 64'(obs_q[obs_q.size() - 1]), 64'(vecs[i].last_w));
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; base_addr = '0;
        byte_data = 8'd0; byte_valid = 1'b0; byte_last = 1'b0;

        // Directed table: base, byte count, first byte (bytes count up),
        // expected words, wrapped, first and last write {addr, we, data}.
        set_vec(0, 12'h010, 4, 8'h11, 1, 1'b0, {12'h010, 4'hF, 32'h44332211}, {12'h010, 4'hF, 32'h44332211});
        vecs[0].b[1] = 8'h22; vecs[0].b[2] = 8'h33; vecs[0].b[3] = 8'h44;
        set_vec(1, 12'h010, 6, 8'h01, 2, 1'b0, {12'h010, 4'hF, 32'h04030201}, {12'h011, 4'h3, 32'h00000605});
        set_vec(2, 12'h123, 1, 8'hAA, 1, 1'b0, {12'h123, 4'h1, 32'h000000AA}, {12'h123, 4'h1, 32'h000000AA});
        set_vec(3, 12'hFFF, 8, 8'h10, 2, 1'b1, {12'hFFF, 4'hF, 32'h13121110}, {12'h000, 4'hF, 32'h17161514});
        set_vec(4, 12'h7FE, 7, 8'hA0, 2, 1'b0, {12'h7FE, 4'hF, 32'hA3A2A1A0}, {12'h7FF, 4'h7, 32'h00A6A5A4});

        repeat (3) @(negedge clk);
        check("reset_ctrl", 64'({byte_ready, busy, done, wrapped, words_written, bram_clken}), 64'd0);
        check("reset_port", 64'({bram_addr, bram_we, bram_data}), 64'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("post_reset_idle", 64'({byte_ready, busy, bram_clken}), 64'd0);

        // Table: without gaps, then again with valid gaps.
        for (int i = 0; i < 5; i++) run_vec(i, 0);
        for (int i = 0; i < 5; i++) run_vec(i, 40);

        // Bytes offered in IDLE are neither accepted nor written.
        obs_q.delete();
        @(negedge clk);
        byte_valid = 1'b1; byte_data = 8'hAB; byte_last = 1'b1;
        repeat (6) @(negedge clk);
        check("idle_byte_ready", 64'(byte_ready), 64'd0);
        byte_valid = 1'b0; byte_last = 1'b0;
        @(negedge clk);
        check("idle_no_write", 64'(obs_q.size()), 64'd0);
        check("idle_not_busy", 64'(busy), 64'd0);

        // Start pulse mid-load carries another base; it must be ignored.
        stim_q = '{8'h5A, 8'h6B, 8'h7C, 8'h8D, 8'h9E};
        run_load(12'h200, 0, 2, 12'h300);
        check("start_ignored_addr", 64'(obs_q[0][47:36]), 64'h200);

        // Reset after two accepted bytes: partial word is dropped.
        @(posedge clk); #1;
        obs_q.delete();
        @(negedge clk); start = 1'b1; base_addr = 12'h020;
        @(negedge clk); start = 1'b0; byte_valid = 1'b1; byte_data = 8'h55; byte_last = 1'b0;
        @(negedge clk); byte_data = 8'h66;
        @(negedge clk); byte_valid = 1'b0; reset = 1'b1;
        @(negedge clk);
        check("midreset_ctrl", 64'({byte_ready, busy, done, wrapped, words_written, bram_clken}), 64'd0);
        check("midreset_port", 64'({bram_addr, bram_we, bram_data}), 64'd0);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("midreset_no_write", 64'(obs_q.size()), 64'd0);
        run_vec(0, 0);

        // Randomized loads against the reference model.
        for (int t = 0; t < 25; t++) begin
            logic [AW-1:0] b;
            int            n;
            if ($urandom_range(3) == 0) b = AW'(12'hFFF - AW'($urandom_range(2)));
            else                        b = AW'($urandom);
            n = int'($urandom_range(1, 13));
            stim_q.delete();
            for (int k = 0; k < n; k++) stim_q.push_back(8'($urandom));
            run_load(b, 30, ($urandom_range(1) == 0) ? int'($urandom_range(n - 1)) : -1, AW'($urandom));
        end

        check("no_we_without_clken", 64'(stray_cnt), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
